// File: rtl/crc8_arbiter.sv
// crc8_arbiter: shares one crc8 engine among NUM_REQ byte-stream requesters.
// A round-robin pointer picks one requester per frame. The engine is cleared,
// the granted bytes are streamed through it, and the final CRC is returned
// with the owner's ID on a valid/ready result port.
module crc8_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // requester side
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  // engine side
  output logic                 eng_clear_o,
  output logic [7:0]           eng_data_o,
  output logic                 eng_valid_o,
  input  logic [7:0]           eng_crc_i,
  // result side
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [7:0]           res_crc_o,
  output logic [ID_W-1:0]      res_id_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_WAIT,
    ST_RESULT
  } state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] grant_reg, grant_next;
  logic [ID_W-1:0] ptr_reg, ptr_next;

  logic            eng_clear_reg;
  logic            res_valid_reg;
  logic [7:0]      res_crc_reg;
  logic [ID_W-1:0] res_id_reg;

  // Per-requester byte lanes, unpacked so the grant can index them directly.
  logic [7:0]      req_byte [NUM_REQ];

  // Round-robin search results.
  logic            any_req;
  logic [ID_W-1:0] rr_pick;
  logic [ID_W-1:0] rr_cand;
  int              rr_idx;

  // Signals of the currently granted requester.
  logic            gnt_valid;
  logic            gnt_last;
  logic [7:0]      gnt_byte;
  logic            in_stream;
  logic            stream_done;

  // Unpack the byte bus and decode the one-hot ready vector per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_byte[gi]    = req_data_i[8*gi +: 8];
      assign req_ready_o[gi] = in_stream && (grant_reg == ID_W'(gi));
    end
  endgenerate

  assign in_stream   = (state_reg == ST_STREAM);
  assign gnt_valid   = req_valid_i[grant_reg];
  assign gnt_last    = req_last_i[grant_reg];
  assign gnt_byte    = req_byte[grant_reg];

  // The granted requester always sees ready in STREAM, so its valid is the
  // handshake; last only counts when it arrives with a valid byte.
  assign eng_valid_o = in_stream && gnt_valid;
  assign eng_data_o  = eng_valid_o ? gnt_byte : 8'h00;
  assign stream_done = eng_valid_o && gnt_last;

  assign eng_clear_o = eng_clear_reg;
  assign res_valid_o = res_valid_reg;
  assign res_crc_o   = res_crc_reg;
  assign res_id_o    = res_id_reg;

  // Round-robin pick: first requesting index at or above ptr, wrapping.
  // Walk offsets from highest to lowest so the smallest offset is kept last.
  always_comb begin
    any_req = 1'b0;
    rr_pick = '0;
    rr_idx  = 0;
    rr_cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rr_idx = int'(ptr_reg) + i;
      if (rr_idx >= NUM_REQ) begin
        rr_idx = rr_idx - NUM_REQ;
      end
      rr_cand = ID_W'(rr_idx);
      if (req_valid_i[rr_cand]) begin
        any_req = 1'b1;
        rr_pick = rr_cand;
      end
    end
  end

  // Next-state, grant and pointer logic of the frame controller.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          grant_next = rr_pick;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        // No timeout: a stalled owner keeps the engine until its last byte.
        if (stream_done) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Engine output is one cycle behind the last byte; sampled here.
        state_next = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready_i) begin
          ptr_next   = (grant_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Controller state, grant and fairness pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Registered strobes, decoded from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eng_clear_reg <= 1'b0;
      res_valid_reg <= 1'b0;
    end else begin
      eng_clear_reg <= (state_next == ST_CLEAR);
      res_valid_reg <= (state_next == ST_RESULT);
    end
  end

  // Result capture; values hold until the next frame reaches WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_crc_reg <= 8'h00;
      res_id_reg  <= '0;
    end else if (state_reg == ST_WAIT) begin
      res_crc_reg <= eng_crc_i;
      res_id_reg  <= grant_reg;
    end
  end

endmodule

// File: tb/tb_crc8_arbiter.sv
// Directed bench for crc8_arbiter with a behavioural CRC-8 (poly 0x07) engine.
module tb_crc8_arbiter;

  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            eng_clear;
  logic [7:0]      eng_data;
  logic            eng_valid;
  logic [7:0]      eng_crc = 8'h00;
  logic            res_valid;
  logic            res_ready;
  logic [7:0]      res_crc;
  logic [IW-1:0]   res_id;

  crc8_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .eng_clear_o (eng_clear),
    .eng_data_o  (eng_data),
    .eng_valid_o (eng_valid),
    .eng_crc_i   (eng_crc),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_crc_o   (res_crc),
    .res_id_o    (res_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // CRC engine: synchronous clear, registered CRC output.
  always @(posedge clk) begin
    if (eng_clear)      eng_crc <= 8'h00;
    else if (eng_valid) eng_crc <= crc_step(eng_crc, eng_data);
  end

  // Stimulus tables per requester.
  logic [7:0] tx_data [NR][16];
  logic       tx_last [NR][16];
  int tx_len [NR];
  int tx_pos [NR];
  int gap_at [NR];
  int gap_len[NR];
  int gap_cnt[NR];
  int hold_cnt;

  // Observation state.
  logic [NR-1:0] hs;
  logic [NR-1:0] ready_seen, ready_since_rise;
  int   clear_cnt, clear_cyc, rise_cyc, vlen, unstable, n_res;
  logic prev_rv;
  logic [7:0] prev_crc;
  logic [IW-1:0] prev_id;
  logic [7:0]    log_crc [16];
  logic [IW-1:0] log_id  [16];
  int            log_rise[16];
  int            log_vlen[16];
  logic [NR-1:0] log_seen[16];
  logic [NR-1:0] log_rr  [16];

  int n_total = 0;
  int n_bad   = 0;
  int t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tx();
    for (int k = 0; k < NR; k++) begin
      tx_len[k] = 0; tx_pos[k] = 0; gap_at[k] = -1; gap_len[k] = 0; gap_cnt[k] = 0;
    end
  endtask

  task automatic begin_test();
    clear_tx();
    n_res = 0; ready_seen = '0; ready_since_rise = '0;
    clear_cnt = 0; clear_cyc = -1; unstable = 0; hold_cnt = 0; vlen = 0;
  endtask

  task automatic load_str(input int k);
    string s;
    s = "123456789";
    for (int i = 0; i < s.len(); i++) begin
      tx_data[k][i] = s[i];
      tx_last[k][i] = (i == s.len() - 1);
    end
    tx_len[k] = s.len();
  endtask

  // Drive valid/data/last per requester; idle lanes show last=1 to prove it is ignored.
  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (tx_pos[k] < tx_len[k] && gap_cnt[k] == 0) begin
        req_valid[k]        = 1'b1;
        req_data[8*k +: 8]  = tx_data[k][tx_pos[k]];
        req_last[k]         = tx_last[k][tx_pos[k]];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[8*k +: 8]  = 8'h5A;
        req_last[k]         = 1'b1;
      end
    end
    res_ready = (hold_cnt == 0);
  endtask

  // One clock: observe at negedge, then advance stimulus just after posedge.
  task automatic step();
    @(negedge clk);
    hs = req_valid & req_ready;
    ready_seen |= req_ready;
    if (eng_clear) begin
      clear_cnt++;
      clear_cyc = cyc;
    end
    if (res_valid) begin
      if (!prev_rv) begin
        rise_cyc = cyc;
        vlen = 0;
        ready_since_rise = '0;
      end else if (res_crc !== prev_crc || res_id !== prev_id) begin
        unstable++;
      end
      ready_since_rise |= req_ready;
      vlen++;
      if (res_ready) begin
        log_crc[n_res]  = res_crc;
        log_id[n_res]   = res_id;
        log_rise[n_res] = rise_cyc;
        log_vlen[n_res] = vlen;
        log_seen[n_res] = ready_seen;
        log_rr[n_res]   = ready_since_rise;
        $display("result id=%0d crc=%02h rise_cycle=%0d held=%0d", res_id, res_crc, rise_cyc, vlen);
        n_res++;
      end
      if (hold_cnt > 0) hold_cnt--;
    end
    prev_rv = res_valid; prev_crc = res_crc; prev_id = res_id;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (gap_cnt[k] > 0) gap_cnt[k]--;
      if (hs[k]) begin
        tx_pos[k]++;
        if (tx_pos[k] == gap_at[k]) gap_cnt[k] = gap_len[k];
      end
    end
    drive();
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_res < target; i++) step();
    check(tag, n_res, target);
  endtask

  task automatic check_zero(input string p);
    check({p, "_res_valid"}, res_valid, 0);
    check({p, "_req_ready"}, req_ready, 0);
    check({p, "_eng_valid"}, eng_valid, 0);
    check({p, "_eng_data"},  eng_data,  0);
    check({p, "_eng_clear"}, eng_clear, 0);
    check({p, "_res_crc"},   res_crc,   0);
    check({p, "_res_id"},    res_id,    0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    begin_test();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_rv = 1'b0;
  endtask

  logic [IW-1:0] exp_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0]    exp_crc [4] = '{8'h07, 8'h0E, 8'h09, 8'h1C};

  initial begin
    rst_n = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b1;
    prev_rv = 1'b0; prev_crc = '0; prev_id = '0;
    begin_test();
    #2;
    do_reset();

    // 1: single nine-byte frame from req0
    begin_test();
    load_str(0);
    drive();
    t0 = cyc;
    run_until(1, 60, "t1_count");
    check("t1_crc",       log_crc[0],  8'hF4);
    check("t1_id",        log_id[0],   0);
    check("t1_rise",      log_rise[0], t0 + 12);
    check("t1_clear_cnt", clear_cnt,   1);
    check("t1_clear_cyc", clear_cyc,   t0 + 1);

    // 2: req0 and req2 together with ptr=0
    do_reset();
    begin_test();
    tx_data[0][0] = 8'h01; tx_last[0][0] = 1'b1; tx_len[0] = 1;
    tx_data[2][0] = 8'h01; tx_last[2][0] = 1'b1; tx_len[2] = 1;
    drive();
    run_until(2, 40, "t2_count");
    check("t2_id0",    log_id[0],  0);
    check("t2_crc0",   log_crc[0], 8'h07);
    check("t2_rdy2",   log_seen[0][2], 0);
    check("t2_id1",    log_id[1],  2);
    check("t2_crc1",   log_crc[1], 8'h07);

    // 3: all requesters continuously offering one-byte frames
    do_reset();
    begin_test();
    for (int k = 0; k < NR; k++) begin
      for (int i = 0; i < 2; i++) begin
        tx_data[k][i] = 8'(k + 1);
        tx_last[k][i] = 1'b1;
      end
      tx_len[k] = 2;
    end
    drive();
    run_until(8, 120, "t3_count");
    for (int i = 0; i < 6; i++) check($sformatf("t3_id%0d", i), log_id[i], exp_id[i]);
    for (int i = 0; i < 4; i++) check($sformatf("t3_crc%0d", i), log_crc[i], exp_crc[i]);

    // 4: req1 with a three-cycle bubble after byte 4 and result back-pressure
    begin_test();
    load_str(1);
    gap_at[1] = 4; gap_len[1] = 3;
    hold_cnt = 5;
    drive();
    t0 = cyc;
    run_until(1, 80, "t4_count");
    check("t4_crc",      log_crc[0],  8'hF4);
    check("t4_id",       log_id[0],   1);
    check("t4_rise",     log_rise[0], t0 + 15);
    check("t4_held",     log_vlen[0], 6);
    check("t4_ready",    log_rr[0],   0);
    check("t4_unstable", unstable,    0);

    // 5: reset after byte 5 of a req3 frame, then req3 full frame racing req1
    begin_test();
    load_str(3);
    drive();
    for (int i = 0; i < 50 && tx_pos[3] < 5; i++) step();
    check("t5_bytes", tx_pos[3], 5);
    rst_n = 1'b0;
    #1;
    check_zero("t5");
    begin_test();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_rv = 1'b0;
    load_str(3);
    tx_data[1][0] = 8'h01; tx_last[1][0] = 1'b1; tx_len[1] = 1;
    drive();
    run_until(2, 80, "t5_count");
    check("t5_id0",  log_id[0],  1);
    check("t5_crc0", log_crc[0], 8'h07);
    check("t5_id1",  log_id[1],  3);
    check("t5_crc1", log_crc[1], 8'hF4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
